// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int LINE_BYTES     = 32;
  localparam int WORDS_PER_LINE = 8;

  typedef logic [26:0] line_tag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// Single-entry cache line holder: tag/valid/data with combinational hit and
// selection of FETCH_WIDTH consecutive words starting at word_idx.
module fetch_line_buffer
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  line_tag_t                load_tag,
  input  logic [255:0]             load_data,
  input  logic                     invalidate,
  input  line_tag_t                lookup_tag,
  input  logic [2:0]               word_idx,
  output logic                     hit,
  output logic [32*FETCH_WIDTH-1:0] words
);

  line_tag_t    tag;
  logic         valid;
  logic [255:0] data;
  logic [3:0]   idx;

  // Load wins over invalidate so a fill is never lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      data  <= load_data;
    end else if (invalidate) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (tag == lookup_tag);

  // Slots that fall past the end of the line read as zero.
  always_comb begin
    words = '0;
    idx   = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      idx = {1'b0, word_idx} + 4'(s);
      if (idx < 4'(WORDS_PER_LINE)) begin
        words[32*s +: 32] = data[32*idx[2:0] +: 32];
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one line buffer, one outstanding icache request, redirect flush.
// Define FETCH_LINEBUF_EN to keep the line buffer across groups.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter logic [31:0] RESET_PC    = 32'haaaaa000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [31:0]               ufp_addr,
  output logic [3:0]                ufp_rmask,
  input  logic [255:0]              ufp_rcache_line,
  input  logic                      ufp_resp,
  input  logic                      redirect_i,
  input  logic [31:0]               redirect_pc_i,
  input  logic                      full_i,
  output logic                      enqueue_o,
  output logic [32*FETCH_WIDTH-1:0] instr_o,
  output logic [FETCH_WIDTH-1:0]    valid_o,
  output logic [31:0]               pc_o,
  output logic [63:0]               order_o,
  output fetch_state_t              fsm_state
);

  fetch_state_t state, next_state;
  logic [31:0]  pc;
  logic [63:0]  order;
  logic         hit, issue, load, invalidate;
  logic [3:0]   rem, k;
  logic         unused_bits;

  assign unused_bits = ^redirect_pc_i[1:0];

  fetch_line_buffer #(.FETCH_WIDTH(FETCH_WIDTH)) u_line_buffer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_tag   (ufp_addr[31:5]),
    .load_data  (ufp_rcache_line),
    .invalidate (invalidate),
    .lookup_tag (pc[31:5]),
    .word_idx   (pc[4:2]),
    .hit        (hit),
    .words      (instr_o)
  );

`ifdef FETCH_LINEBUF_EN
  assign invalidate = 1'b0;
`else
  assign invalidate = enqueue_o;
`endif

  // A group never crosses the current line.
  assign rem       = 4'(WORDS_PER_LINE) - {1'b0, pc[4:2]};
  assign k         = (rem < 4'(FETCH_WIDTH)) ? rem : 4'(FETCH_WIDTH);
  assign enqueue_o = hit && !full_i && !redirect_i;

  always_comb begin
    valid_o = '0;
    for (int s = 0; s < FETCH_WIDTH; s++) begin
      valid_o[s] = enqueue_o && (4'(s) < k);
    end
  end

  // Icache handshake: rmask stays '1 from issue until the ufp_resp pulse.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    load       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redirect_i && !hit) begin
          next_state = REQ;
          issue      = 1'b1;
        end
      end
      REQ: begin
        if (ufp_resp) begin
          next_state = IDLE;
          load       = !redirect_i;
        end else if (redirect_i) begin
          next_state = DROP;
        end
      end
      DROP: begin
        if (ufp_resp) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      order    <= '0;
      ufp_addr <= '0;
    end else begin
      state <= next_state;
      if (issue) ufp_addr <= {pc[31:5], 5'b0};
      if (redirect_i) begin
        pc <= {redirect_pc_i[31:2], 2'b00};
      end else if (enqueue_o) begin
        pc    <= pc + {26'b0, k, 2'b00};
        order <= order + {60'b0, k};
      end
    end
  end

  assign ufp_rmask = (state == IDLE) ? 4'h0 : 4'hf;
  assign pc_o      = pc;
  assign order_o   = order;
  assign fsm_state = state;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a FETCH_WIDTH=2 instance with a simple icache
// model, plus a FETCH_WIDTH=4 instance driven by hand.
module tb_fetch_unit;
  import fetch_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // FETCH_WIDTH=2 instance
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [255:0] line;
  logic         resp, redirect, full, enq;
  logic [31:0]  redirect_pc, pc;
  logic [63:0]  instr, order;
  logic [1:0]   valid;
  fetch_state_t st;

  fetch_unit #(.FETCH_WIDTH(2), .RESET_PC(32'haaaaa000)) dut (
    .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
    .ufp_rcache_line(line), .ufp_resp(resp), .redirect_i(redirect),
    .redirect_pc_i(redirect_pc), .full_i(full), .enqueue_o(enq), .instr_o(instr),
    .valid_o(valid), .pc_o(pc), .order_o(order), .fsm_state(st)
  );

  // FETCH_WIDTH=4 instance
  logic [31:0]  w_addr, w_redirect_pc, w_pc;
  logic [3:0]   w_rmask, w_valid;
  logic [255:0] w_line;
  logic         w_resp, w_redirect, w_full, w_enq;
  logic [127:0] w_instr;
  logic [63:0]  w_order;
  fetch_state_t w_st;

  fetch_unit #(.FETCH_WIDTH(4), .RESET_PC(32'haaaaa000)) dut4 (
    .clk(clk), .rst(rst), .ufp_addr(w_addr), .ufp_rmask(w_rmask),
    .ufp_rcache_line(w_line), .ufp_resp(w_resp), .redirect_i(w_redirect),
    .redirect_pc_i(w_redirect_pc), .full_i(w_full), .enqueue_o(w_enq), .instr_o(w_instr),
    .valid_o(w_valid), .pc_o(w_pc), .order_o(w_order), .fsm_state(w_st)
  );

  int passed = 0;
  int total  = 0;

  // icache model state for the width-2 instance
  logic        ic_busy;
  int          ic_cnt, ic_lat, req_count;
  logic [31:0] ic_addr;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mk_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h5eed0000;
  endfunction

  function automatic logic [255:0] mk_line(input logic [31:0] a);
    logic [255:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = mk_word({a[31:5], 3'(i), 2'b00});
    return l;
  endfunction

  // driver tasks: one clock step, icache answers ic_lat cycles after a request
  task automatic tick();
    @(posedge clk);
    #1;
    resp = 1'b0;
    if (ufp_rmask != 4'h0 && !ic_busy) begin
      ic_busy = 1'b1; ic_cnt = ic_lat; ic_addr = ufp_addr; req_count++;
    end
    if (ic_busy) begin
      if (ic_cnt == 0) begin
        resp = 1'b1; line = mk_line(ic_addr); ic_busy = 1'b0;
      end else begin
        ic_cnt--;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    redirect = 0; redirect_pc = '0; full = 0; resp = 0; line = '0;
    w_redirect = 0; w_redirect_pc = '0; w_full = 0; w_resp = 0; w_line = '0;
    ic_busy = 0; ic_cnt = 0; ic_lat = 1; req_count = 0;
    rst = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1;
  endtask

  task automatic test_reset();
    logic got;
    do_reset();
    ic_lat = 5;
    tick();
    total++; if (ufp_rmask !== 4'hf) $display("FAIL first_req_rmask got=%h exp=f", ufp_rmask); else passed++;
    total++; if (ufp_addr !== 32'haaaaa000) $display("FAIL first_req_addr got=%h exp=aaaaa000", ufp_addr); else passed++;
    tick();
    rst = 0;  // asynchronous, mid-request
    #1;
    total++; if (pc !== 32'haaaaa000) $display("FAIL reset_pc got=%h exp=aaaaa000", pc); else passed++;
    total++; if (order !== 64'd0) $display("FAIL reset_order got=%0d exp=0", order); else passed++;
    total++; if (ufp_rmask !== 4'h0) $display("FAIL reset_rmask got=%h exp=0", ufp_rmask); else passed++;
    total++; if (ufp_addr !== 32'h0) $display("FAIL reset_addr got=%h exp=0", ufp_addr); else passed++;
    total++; if (enq !== 1'b0 || valid !== 2'b00) $display("FAIL reset_enq got=%b/%b exp=0/00", enq, valid); else passed++;
    total++; if (st !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", st, IDLE); else passed++;
    @(posedge clk);
    #2;
    ic_busy = 0; ic_lat = 1; req_count = 0;
    resp = 1; line = '1;  // stale response on the deassertion cycle
    rst = 1;
    tick();
    total++; if (st !== REQ || ufp_addr !== 32'haaaaa000) $display("FAIL stale_resp_state got=%0d/%h exp=%0d/aaaaa000", st, ufp_addr, REQ); else passed++;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = enq;
    end
    total++; if (!got || instr !== {mk_word(32'haaaaa004), mk_word(32'haaaaa000)}) $display("FAIL stale_resp_data got=%h exp=%h", instr, {mk_word(32'haaaaa004), mk_word(32'haaaaa000)}); else passed++;
  endtask

  task automatic test_sequential();
    logic [31:0] e;
    logic [63:0] exp_order;
    int n, reqs, exp_reqs;
`ifdef FETCH_LINEBUF_EN
    exp_reqs = 1;
`else
    exp_reqs = 4;
`endif
    do_reset();
    exp_q = {32'haaaaa000, 32'haaaaa008, 32'haaaaa010, 32'haaaaa018};
    exp_order = 0; n = 0; reqs = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (enq) begin
        e = exp_q.pop_front();
        total++; if (pc !== e) $display("FAIL seq_pc got=%h exp=%h", pc, e); else passed++;
        total++; if (valid !== 2'b11) $display("FAIL seq_valid got=%b exp=11", valid); else passed++;
        total++; if (order !== exp_order) $display("FAIL seq_order got=%0d exp=%0d", order, exp_order); else passed++;
        total++; if (instr !== {mk_word(e + 32'd4), mk_word(e)}) $display("FAIL seq_instr got=%h exp=%h", instr, {mk_word(e + 32'd4), mk_word(e)}); else passed++;
        exp_order += 2; n++;
        if (n == 4) reqs = req_count;
      end
    end
    total++; if (n !== 4) $display("FAIL seq_groups got=%0d exp=4", n); else passed++;
    total++; if (reqs !== exp_reqs) $display("FAIL seq_requests got=%0d exp=%0d", reqs, exp_reqs); else passed++;
  endtask

  task automatic test_full();
    logic got;
    do_reset();
    full = 1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = resp;
    end
    total++; if (!got) $display("FAIL full_resp got=0 exp=1"); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (enq !== 1'b0) $display("FAIL full_enq got=%b exp=0", enq); else passed++;
      total++; if (pc !== 32'haaaaa000) $display("FAIL full_pc got=%h exp=aaaaa000", pc); else passed++;
      total++; if (ufp_rmask !== 4'h0) $display("FAIL full_rmask got=%h exp=0", ufp_rmask); else passed++;
    end
    full = 0;
    #1;
    total++; if (enq !== 1'b1 || valid !== 2'b11) $display("FAIL full_release got=%b/%b exp=1/11", enq, valid); else passed++;
    tick();
    total++; if (pc !== 32'haaaaa008) $display("FAIL full_pc_adv got=%h exp=aaaaa008", pc); else passed++;
  endtask

  task automatic test_boundary();
    logic got;
    do_reset();
    redirect = 1; redirect_pc = 32'haaaaa01f;
    tick();
    redirect = 0;
    #1;
    total++; if (pc !== 32'haaaaa01c || ufp_rmask !== 4'h0) $display("FAIL bnd_redirect got=%h/%h exp=aaaaa01c/0", pc, ufp_rmask); else passed++;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      got = enq;
    end
    total++; if (!got || valid !== 2'b01) $display("FAIL bnd_valid got=%b exp=01", valid); else passed++;
    total++; if (instr[31:0] !== mk_word(32'haaaaa01c)) $display("FAIL bnd_instr got=%h exp=%h", instr[31:0], mk_word(32'haaaaa01c)); else passed++;
    tick();
    total++; if (pc !== 32'haaaaa020 || order !== 64'd1) $display("FAIL bnd_next got=%h/%0d exp=aaaaa020/1", pc, order); else passed++;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = (ufp_rmask == 4'hf);
    end
    total++; if (!got || ufp_addr !== 32'haaaaa020) $display("FAIL bnd_req_addr got=%h exp=aaaaa020", ufp_addr); else passed++;
    full = 1;
    got = resp;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = resp;
    end
    tick();
    redirect = 1; redirect_pc = 32'haaaaa034; full = 0;
    #1;
    total++; if (enq !== 1'b0) $display("FAIL redirect_priority got=%b exp=0", enq); else passed++;
    tick();
    redirect = 0;
    #1;
    total++; if (enq !== 1'b1 || pc !== 32'haaaaa034) $display("FAIL redirect_hit got=%b/%h exp=1/aaaaa034", enq, pc); else passed++;
    total++; if (instr !== {mk_word(32'haaaaa038), mk_word(32'haaaaa034)}) $display("FAIL redirect_hit_instr got=%h exp=%h", instr, {mk_word(32'haaaaa038), mk_word(32'haaaaa034)}); else passed++;
    total++; if (order !== 64'd1 || ufp_rmask !== 4'h0) $display("FAIL redirect_hit_order got=%0d/%h exp=1/0", order, ufp_rmask); else passed++;
  endtask

  task automatic test_drop();
    logic got;
    do_reset();
    ic_lat = 3;
    redirect = 1; redirect_pc = 32'haaaaa020;
    tick();
    redirect = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = (ufp_rmask == 4'hf);
    end
    total++; if (!got || ufp_addr !== 32'haaaaa020) $display("FAIL drop_req_addr got=%h exp=aaaaa020", ufp_addr); else passed++;
    redirect = 1; redirect_pc = 32'haaaab000;
    tick();
    redirect = 0;
    #1;
    total++; if (st !== DROP || ufp_rmask !== 4'hf || ufp_addr !== 32'haaaaa020) $display("FAIL drop_state got=%0d/%h/%h exp=%0d/f/aaaaa020", st, ufp_rmask, ufp_addr, DROP); else passed++;
    got = 0;
    for (int c = 0; c < 30 && !got; c++) begin
      tick();
      got = enq;
    end
    total++; if (!got || pc !== 32'haaaab000) $display("FAIL drop_first_enq got=%h exp=aaaab000", pc); else passed++;
    total++; if (instr !== {mk_word(32'haaaab004), mk_word(32'haaaab000)}) $display("FAIL drop_instr got=%h exp=%h", instr, {mk_word(32'haaaab004), mk_word(32'haaaab000)}); else passed++;
    total++; if (req_count !== 2 || ic_addr !== 32'haaaab000) $display("FAIL drop_reqs got=%0d/%h exp=2/aaaab000", req_count, ic_addr); else passed++;
  endtask

  task automatic test_redirect_resp();
    logic got;
    do_reset();
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = resp;
    end
    redirect = 1; redirect_pc = 32'haaaac004;
    tick();
    redirect = 0;
    #1;
    total++; if (st !== IDLE || enq !== 1'b0 || pc !== 32'haaaac004) $display("FAIL rr_discard got=%0d/%b/%h exp=%0d/0/aaaac004", st, enq, pc, IDLE); else passed++;
    tick();
    total++; if (ufp_rmask !== 4'hf || ufp_addr !== 32'haaaac000) $display("FAIL rr_req got=%h/%h exp=f/aaaac000", ufp_rmask, ufp_addr); else passed++;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = enq;
    end
    total++; if (!got || pc !== 32'haaaac004 || valid !== 2'b11 || order !== 64'd0) $display("FAIL rr_enq got=%h/%b/%0d exp=aaaac004/11/0", pc, valid, order); else passed++;
    total++; if (instr !== {mk_word(32'haaaac008), mk_word(32'haaaac004)}) $display("FAIL rr_instr got=%h exp=%h", instr, {mk_word(32'haaaac008), mk_word(32'haaaac004)}); else passed++;
  endtask

  task automatic test_width4();
    logic got;
    do_reset();
    w_redirect = 1; w_redirect_pc = 32'haaaaa018;
    tick();
    w_redirect = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      got = (w_rmask == 4'hf);
    end
    total++; if (!got || w_addr !== 32'haaaaa000) $display("FAIL w4_req_addr got=%h exp=aaaaa000", w_addr); else passed++;
    w_resp = 1; w_line = mk_line(32'haaaaa000);
    tick();
    w_resp = 0;
    #1;
    total++; if (w_enq !== 1'b1 || w_valid !== 4'b0011 || w_pc !== 32'haaaaa018) $display("FAIL w4_group got=%b/%b/%h exp=1/0011/aaaaa018", w_enq, w_valid, w_pc); else passed++;
    total++; if (w_instr[63:0] !== {mk_word(32'haaaaa01c), mk_word(32'haaaaa018)}) $display("FAIL w4_instr got=%h exp=%h", w_instr[63:0], {mk_word(32'haaaaa01c), mk_word(32'haaaaa018)}); else passed++;
    tick();
    total++; if (w_pc !== 32'haaaaa020 || w_order !== 64'd2 || w_enq !== 1'b0) $display("FAIL w4_next got=%h/%0d/%b exp=aaaaa020/2/0", w_pc, w_order, w_enq); else passed++;
    tick();
    total++; if (w_rmask !== 4'hf || w_addr !== 32'haaaaa020) $display("FAIL w4_new_req got=%h/%h exp=f/aaaaa020", w_rmask, w_addr); else passed++;
  endtask

  initial begin
    rst = 0;
    test_reset();
    test_sequential();
    test_full();
    test_boundary();
    test_drop();
    test_redirect_resp();
    test_width4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter FETCH_WIDTH, default 2, instructions per fetch group; legal values 1, 2, 4.
REQ-002 Parameter RESET_PC, default 32'haaaaa000, PC loaded at reset.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 ufp_addr  output  32  icache request address, line-aligned (bits [4:0] zero).
REQ-006 ufp_rmask  output  4  icache read mask; '1 requests a line, '0 idles.
REQ-007 ufp_rcache_line  input  256  returned 32-byte line, word i at bits [32*i +: 32].
REQ-008 ufp_resp  input  1  one-cycle pulse marking ufp_rcache_line valid.
REQ-009 redirect_i  input  1  flush and redirect fetch (branch/exception).
REQ-010 redirect_pc_i  input  32  new PC; bits [1:0] ignored.
REQ-011 full_i  input  1  instruction queue cannot accept a group this cycle.
REQ-012 enqueue_o  output  1  group on instr_o/valid_o/pc_o/order_o written to queue this cycle.
REQ-013 instr_o  output  32*FETCH_WIDTH  slot s instruction at bits [32*s +: 32].
REQ-014 valid_o  output  FETCH_WIDTH  per-slot valid, contiguous from slot 0.
REQ-015 pc_o  output  32  PC of slot 0.
REQ-016 order_o  output  64  retire-order index of slot 0.

Function
REQ-017 States: IDLE (no request in flight), REQ (request in flight), DROP (in-flight request to discard).
REQ-018 Hit: line buffer valid and its tag equals pc[31:5]; hit evaluated combinationally in any state.
REQ-019 Group size k = min(FETCH_WIDTH, 8 - pc[4:2]); groups never cross a 32-byte line.
REQ-020 enqueue_o = hit && !full_i && !redirect_i; valid_o low bits [k-1:0] set only when enqueue_o, else all zero.
REQ-021 On enqueue: pc += 4*k, order_o += k, in the same edge.
REQ-022 IDLE, no hit, no redirect: drive ufp_addr = {pc[31:5],5'b0}, ufp_rmask = '1, go REQ next cycle.
REQ-023 REQ: ufp_addr and ufp_rmask held stable until ufp_resp; on ufp_resp load line buffer (tag pc[31:5], data), rmask '0, go IDLE; group enqueues earliest the following cycle.
REQ-024 redirect_i has highest priority: pc <= {redirect_pc_i[31:2],2'b00}, no enqueue that cycle, order_o unchanged.
REQ-025 redirect_i in REQ without ufp_resp: go DROP, rmask held '1 until resp; redirect_i with ufp_resp in same cycle: line discarded, go IDLE.
REQ-026 DROP: on ufp_resp discard line, rmask '0, go IDLE; further redirect_i in DROP updates pc, stays DROP.
REQ-027 full_i stalls: pc, order_o, line buffer unchanged; no new icache request issued while a hit is stalled.
REQ-028 Line buffer is not invalidated by redirect_i; a redirect into the buffered line hits immediately.

Reset
REQ-029 rst low asynchronously forces: pc = RESET_PC, order_o = 0, state IDLE, line buffer invalid, ufp_rmask = '0, ufp_addr = 0, enqueue_o = 0, valid_o = 0.
REQ-030 Reset mid-request: in-flight response arriving after rst deasserts is ignored; first request issues the cycle after deassertion.

Configuration
REQ-031 Macro FETCH_LINEBUF_EN defined: line buffer retained across groups per REQ-018..028.
REQ-032 FETCH_LINEBUF_EN undefined: line buffer invalidated on every enqueue, so each group costs one icache request; all other behaviour identical.

Structure
REQ-033 Package fetch_pkg holds the state enum (IDLE, REQ, DROP), LINE_BYTES = 32, WORDS_PER_LINE = 8, line tag type.
REQ-034 One sub-module, fetch_line_buffer: tag, valid, 256-bit data, load/invalidate ports, combinational hit and word-select outputs.

Verification
REQ-035 FETCH_WIDTH=2, reset, line at 32'haaaaa000 = words 0..7 -> one request; four enqueues, pc_o aaaaa000/008/010/018, valid_o 2'b11, order_o 0/2/4/6.
REQ-036 FETCH_WIDTH=4, redirect_pc_i 32'haaaaa018 -> group valid_o 4'b0011 at pc aaaaa018, next pc aaaaa020 triggers new request.
REQ-037 full_i held high 5 cycles after line load -> enqueue_o low, pc frozen, no icache request; release -> enqueue next cycle.
REQ-038 redirect_i to 32'haaaab000 while REQ for aaaaa020 -> DROP, stale line never enqueued, then request for aaaab000.
REQ-039 redirect_i coincident with ufp_resp -> line discarded, IDLE, next request at redirect target.
REQ-040 FETCH_LINEBUF_EN undefined, FETCH_WIDTH=2 -> four icache requests for line aaaaa000, identical instr_o sequence to REQ-035.
